// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - bus-slave memory responder with wait states; optional timer/IRQ via MEM_RESPONDER_IRQ_EN
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] AddrData,
  output logic [15:0] DataOut,
  input  logic        ALE,
  input  logic        nME,
  input  logic        nOE,
  input  logic        RnW,
  output logic        nWait
`ifdef MEM_RESPONDER_IRQ_EN
  ,
  output logic        nIRQ
`endif
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [2:0] {IDLE, ARMED, WAIT, ACCESS, HOLD} stateT;

  stateT              state, nextState;
  logic [15:0]        addrQ;
  logic [15:0]        rdataQ;
  logic [3:0]         wcnt;
  logic [15:0]        mem [DEPTH];
  logic [ADDR_W-1:0]  ramIdx;
  logic               inRange;
  logic               isTimer;
  logic               doRead;
  logic               doWrite;

  assign ramIdx  = addrQ[ADDR_W-1:0];
  assign inRange = (addrQ >> ADDR_W) == 16'h0000;
  assign DataOut = nOE ? 16'h0000 : rdataQ;

`ifdef MEM_RESPONDER_IRQ_EN
  logic [15:0] tcnt;
  // The top word of the RAM window is taken over by the timer.
  assign isTimer = inRange && (ramIdx == {ADDR_W{1'b1}});
`else
  assign isTimer = 1'b0;
`endif

  // Next-state decode; a high nME in WAIT or ACCESS aborts the cycle.
  always_comb begin
    nextState = state;
    doRead    = 1'b0;
    doWrite   = 1'b0;
    case (state)
      IDLE:    if (ALE) nextState = ARMED;
      // A repeated ALE keeps us in ARMED so the last address wins.
      ARMED:   if (!ALE && !nME) nextState = (WS != 4'd0) ? WAIT : ACCESS;
      WAIT: begin
        if (nME)             nextState = IDLE;
        else if (wcnt == 4'd1) nextState = ACCESS;
      end
      ACCESS: begin
        if (nME) begin
          nextState = IDLE;
        end else begin
          nextState = HOLD;
          doRead    = RnW;
          doWrite   = !RnW;
        end
      end
      HOLD:    if (nME) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register plus address latch, wait counter, read data and nWait.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state  <= IDLE;
      addrQ  <= 16'h0000;
      rdataQ <= 16'h0000;
      wcnt   <= 4'd0;
      nWait  <= 1'b1;
    end else begin
      state <= nextState;
      nWait <= !((nextState == WAIT) || (nextState == ACCESS));
      if (ALE && ((state == IDLE) || (state == ARMED)))
        addrQ <= AddrData;
      if ((state == ARMED) && (nextState == WAIT))
        wcnt <= WS;
      else if ((state == WAIT) && (nextState == WAIT))
        wcnt <= wcnt - 4'd1;
      if (doRead) begin
`ifdef MEM_RESPONDER_IRQ_EN
        if (isTimer)      rdataQ <= tcnt;
        else if (inRange) rdataQ <= mem[ramIdx];
        else              rdataQ <= 16'h0000;
`else
        rdataQ <= inRange ? mem[ramIdx] : 16'h0000;
`endif
      end
    end
  end

  // RAM write port; out-of-range and timer writes never reach the array.
  always_ff @(posedge Clock) begin
    if (doWrite && inRange && !isTimer)
      mem[ramIdx] <= AddrData;
  end

`ifdef MEM_RESPONDER_IRQ_EN
  // Interval timer: load on write, count down to zero, raise IRQ on 1->0, clear on read.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      tcnt <= 16'h0000;
      nIRQ <= 1'b1;
    end else if (doWrite && isTimer) begin
      tcnt <= AddrData;
      nIRQ <= 1'b1;
    end else begin
      if (tcnt != 16'h0000) tcnt <= tcnt - 16'h0001;
      if (tcnt == 16'h0001) nIRQ <= 1'b0;
      if (doRead && isTimer) nIRQ <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed bench for mem_responder (2-wait and 0-wait instances on one bus)
module tb_mem_responder;

  logic        Clock = 1'b0;
  logic        nReset;
  logic [15:0] AddrData;
  logic        ALE, nME, nOE, RnW;
  logic [15:0] dataOut2, dataOut0;
  logic        nWait2, nWait0;
`ifdef MEM_RESPONDER_IRQ_EN
  logic        nIrq2, nIrq0;
`endif

  int nVectors     = 0;
  int nMiscompares = 0;

  always #5 Clock = ~Clock;

  mem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dutSlow (
    .Clock(Clock), .nReset(nReset), .AddrData(AddrData), .DataOut(dataOut2),
    .ALE(ALE), .nME(nME), .nOE(nOE), .RnW(RnW), .nWait(nWait2)
`ifdef MEM_RESPONDER_IRQ_EN
    , .nIRQ(nIrq2)
`endif
  );

  mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dutFast (
    .Clock(Clock), .nReset(nReset), .AddrData(AddrData), .DataOut(dataOut0),
    .ALE(ALE), .nME(nME), .nOE(nOE), .RnW(RnW), .nWait(nWait0)
`ifdef MEM_RESPONDER_IRQ_EN
    , .nIRQ(nIrq0)
`endif
  );

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full bus cycle; lowCycles counts negedges with nWait low, rdOut is DataOut when nWait rises.
  task automatic doAccess(input bit useFast, input logic [15:0] addr, input logic [15:0] data,
                          input bit rnw, output int lowCycles, output logic [15:0] rdOut);
    bit done;
    logic w;
    done      = 1'b0;
    lowCycles = 0;
    rdOut     = 16'hxxxx;
    @(negedge Clock);
    ALE = 1'b1; nME = 1'b1; AddrData = addr;
    @(negedge Clock);
    ALE = 1'b0; nME = 1'b0; RnW = rnw; AddrData = data; nOE = rnw ? 1'b0 : 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge Clock);
      w = useFast ? nWait0 : nWait2;
      if (!w) lowCycles++;
      else if (lowCycles > 0) begin
        done  = 1'b1;
        rdOut = useFast ? dataOut0 : dataOut2;
      end
    end
    if (!done) checkVal("nWaitTimeout", 16'h0000, 16'h0001);
    nME = 1'b1;
    @(negedge Clock);
    nOE = 1'b1;
  endtask

  initial begin
    int lc;
    logic [15:0] rd;
    nReset = 1'b0; AddrData = 16'h0000; ALE = 1'b0; nME = 1'b1; nOE = 1'b0; RnW = 1'b1;
    repeat (2) @(negedge Clock);
    checkVal("rstNWait2", 16'(nWait2), 16'h0001);
    checkVal("rstNWait0", 16'(nWait0), 16'h0001);
    checkVal("rstData2", dataOut2, 16'h0000);
`ifdef MEM_RESPONDER_IRQ_EN
    checkVal("rstNIrq", 16'(nIrq2), 16'h0001);
`endif
    nReset = 1'b1;

    // two wait states: write then read back
    doAccess(1'b0, 16'h0012, 16'hBEEF, 1'b0, lc, rd);
    checkVal("wrLow3", 16'(lc), 16'd3);
    doAccess(1'b0, 16'h0012, 16'h0000, 1'b1, lc, rd);
    checkVal("rdLow3", 16'(lc), 16'd3);
    checkVal("rdBeef", rd, 16'hBEEF);
    #1 checkVal("rdGateOff", dataOut2, 16'h0000);

    // zero wait states
    doAccess(1'b0, 16'h0003, 16'h1234, 1'b0, lc, rd);
    doAccess(1'b1, 16'h0003, 16'h0000, 1'b1, lc, rd);
    checkVal("fastLow1", 16'(lc), 16'd1);
    checkVal("fastRd", rd, 16'h1234);

    // out of range
    doAccess(1'b0, 16'h0412, 16'h5555, 1'b0, lc, rd);
    checkVal("oorWrLow", 16'(lc), 16'd3);
    doAccess(1'b0, 16'h0012, 16'h0000, 1'b1, lc, rd);
    checkVal("oorAlias", rd, 16'hBEEF);
    doAccess(1'b0, 16'h0412, 16'h0000, 1'b1, lc, rd);
    checkVal("oorRdLow", 16'(lc), 16'd3);
    checkVal("oorRd", rd, 16'h0000);

    // abort with double ALE
    doAccess(1'b0, 16'h0001, 16'h0101, 1'b0, lc, rd);
    doAccess(1'b0, 16'h0002, 16'h0A0A, 1'b0, lc, rd);
    @(negedge Clock); ALE = 1'b1; AddrData = 16'h0001;
    @(negedge Clock); AddrData = 16'h0002;
    @(negedge Clock); ALE = 1'b0; nME = 1'b0; RnW = 1'b0; AddrData = 16'hDEAD;
    @(negedge Clock);
    checkVal("abortInWait", 16'(nWait2), 16'h0000);
    nME = 1'b1;
    @(negedge Clock);
    checkVal("abortNWait", 16'(nWait2), 16'h0001);
    doAccess(1'b0, 16'h0002, 16'h0000, 1'b1, lc, rd);
    checkVal("abortAddr2", rd, 16'h0A0A);
    doAccess(1'b0, 16'h0001, 16'h0000, 1'b1, lc, rd);
    checkVal("abortAddr1", rd, 16'h0101);
    doAccess(1'b0, 16'h0002, 16'hDEAD, 1'b0, lc, rd);
    doAccess(1'b0, 16'h0001, 16'h0000, 1'b1, lc, rd);
    checkVal("retryAddr1", rd, 16'h0101);
    doAccess(1'b0, 16'h0002, 16'h0000, 1'b1, lc, rd);
    checkVal("retryAddr2", rd, 16'hDEAD);

    // reset mid-cycle
    @(negedge Clock); ALE = 1'b1; AddrData = 16'h0012;
    @(negedge Clock); ALE = 1'b0; nME = 1'b0; RnW = 1'b1; nOE = 1'b0;
    @(negedge Clock);
    checkVal("midInWait", 16'(nWait2), 16'h0000);
    checkVal("midDataPre", dataOut2, 16'hDEAD);
    nReset = 1'b0;
    #1;
    checkVal("midRstNWait", 16'(nWait2), 16'h0001);
    checkVal("midRstData", dataOut2, 16'h0000);
    @(negedge Clock); nReset = 1'b1; nME = 1'b1; nOE = 1'b1;
    doAccess(1'b0, 16'h0012, 16'h0000, 1'b1, lc, rd);
    checkVal("postRstLow", 16'(lc), 16'd3);
    checkVal("postRstRd", rd, 16'hBEEF);

`ifdef MEM_RESPONDER_IRQ_EN
    begin
      int edges;
      bit seen;
      doAccess(1'b0, 16'h03FF, 16'd5, 1'b0, lc, rd);
      checkVal("irqHighAfterLoad", 16'(nIrq2), 16'h0001);
      edges = 1;
      seen  = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge Clock);
        edges++;
        if (!nIrq2) seen = 1'b1;
      end
      checkVal("irqDelay", 16'(edges), 16'd5);
      doAccess(1'b0, 16'h03FF, 16'h0000, 1'b1, lc, rd);
      checkVal("timerRd", rd, 16'h0000);
      checkVal("irqCleared", 16'(nIrq2), 16'h0001);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
